// File: rtl/num_entry.sv
// Calculator number-entry block: builds a BCD significand/exponent from keypresses,
// accepts loaded results and reports the terminating operator.
package calc_pkg;
    localparam int NumDigits = 8;
    localparam int ExpW      = $clog2(NumDigits);

    typedef enum logic [4:0] {
        B_0, B_1, B_2, B_3, B_4, B_5, B_6, B_7, B_8, B_9,
        B_DOT, B_DIV, B_MUL, B_SUB, B_ADD, B_OP_EQ, B_CLEAR,
        B_MEM_ADD, B_MEM_SUB, B_MEM_RECALL, B_MEM_CLEAR,
        B_PERCENT, B_SQRT, B_NONE,
        B_UNKNOWN = 5'd31
    } active_button_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV
    } op_t;

    typedef struct packed {
        logic                   sign;
        logic                   error;
        logic [ExpW-1:0]        exponent;
        logic [4*NumDigits-1:0] significand;
    } num_t;

    function automatic op_t button2op(input active_button_t b);
        case (b)
            B_ADD:   return OP_ADD;
            B_SUB:   return OP_SUB;
            B_MUL:   return OP_MUL;
            B_DIV:   return OP_DIV;
            default: return OP_NONE;
        endcase
    endfunction
endpackage

module num_entry #(
    parameter int NumDigits = calc_pkg::NumDigits,
    parameter int ExpW      = $clog2(NumDigits)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            button_valid_i,
    input  logic [4:0]                      button_i,
    input  logic                            load_valid_i,
    input  logic [2+ExpW+4*NumDigits-1:0]   load_num_i,
    output logic [2+ExpW+4*NumDigits-1:0]   num_o,
    output logic [$clog2(NumDigits+1)-1:0]  digit_count_o,
    output logic                            entry_done_o,
    output logic [2:0]                      done_op_o,
    output logic                            overflow_o
);
    import calc_pkg::*;

    localparam int SigW = 4 * NumDigits;
    localparam int CntW = $clog2(NumDigits + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(NumDigits);

    typedef enum logic [1:0] {S_IDLE, S_INT, S_FRAC, S_ERROR} state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic              err_q, err_d;
    logic [ExpW-1:0]   exp_q, exp_d;
    logic [SigW-1:0]   sig_q, sig_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    op_t               op_q, op_d;
    logic              ovf_q, ovf_d;

    active_button_t    btn;
    logic              is_digit, is_dot, is_op, is_clear;
    logic [3:0]        digit;
    logic [SigW-1:0]   sig_shift;

    assign btn       = active_button_t'(button_i);
    assign is_digit  = button_i <= 5'd9;
    assign digit     = button_i[3:0];
    assign is_dot    = btn == B_DOT;
    assign is_clear  = btn == B_CLEAR;
    assign is_op     = btn inside {B_DIV, B_MUL, B_SUB, B_ADD, B_OP_EQ};
    assign sig_shift = {sig_q[SigW-5:0], digit};

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        err_d   = err_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        op_d    = OP_NONE;
        ovf_d   = 1'b0;

        if (button_valid_i && is_clear) begin
            state_d = S_IDLE;
            sign_d  = 1'b0;
            err_d   = 1'b0;
            exp_d   = '0;
            sig_d   = '0;
            cnt_d   = '0;
        end else if (load_valid_i) begin
            {sign_d, err_d, exp_d, sig_d} = load_num_i;
            cnt_d   = '0;
            state_d = load_num_i[2+ExpW+SigW-2] ? S_ERROR : S_IDLE;
        end else if (button_valid_i && state_q != S_ERROR) begin
            if (is_op) begin
                done_d  = 1'b1;
                op_d    = button2op(btn);
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Any digit or dot starts a fresh number, discarding the shown one.
                        if (is_digit || is_dot) begin
                            sign_d = 1'b0;
                            err_d  = 1'b0;
                            exp_d  = '0;
                            sig_d  = is_digit ? SigW'(digit) : '0;
                        end
                        if (is_digit) begin
                            cnt_d   = (digit != 4'd0) ? CntW'(1) : '0;
                            state_d = S_INT;
                        end else if (is_dot) begin
                            cnt_d   = CntW'(1);
                            state_d = S_FRAC;
                        end
                    end
                    S_INT: begin
                        if (is_digit && !(cnt_q == '0 && digit == 4'd0)) begin
                            if (cnt_q == CntMax) begin
                                ovf_d = 1'b1;
                            end else begin
                                sig_d = sig_shift;
                                cnt_d = cnt_q + CntW'(1);
                            end
                        end else if (is_dot) begin
                            if (cnt_q == CntMax) begin
                                ovf_d = 1'b1;
                            end else begin
                                state_d = S_FRAC;
                                if (cnt_q == '0) cnt_d = CntW'(1);
                            end
                        end
                    end
                    S_FRAC: begin
                        if (is_digit) begin
                            if (cnt_q == CntMax) begin
                                ovf_d = 1'b1;
                            end else begin
                                sig_d = sig_shift;
                                cnt_d = cnt_q + CntW'(1);
                                exp_d = exp_q + ExpW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            exp_q   <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            op_q    <= OP_NONE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
        end
    end

    assign num_o         = {sign_q, err_q, exp_q, sig_q};
    assign digit_count_o = cnt_q;
    assign entry_done_o  = done_q;
    assign done_op_o     = op_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_num_entry.sv
// Bench for num_entry: directed key sequences plus random strobes against a
// digit-list reference model.
module tb_num_entry;
    import calc_pkg::*;

    localparam int N  = 8;
    localparam int EW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int NW = 2 + EW + 4 * N;

    localparam int M_IDLE = 0;
    localparam int M_INT  = 1;
    localparam int M_FRAC = 2;
    localparam int M_ERR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          button_valid;
    logic [4:0]    button;
    logic          load_valid;
    logic [NW-1:0] load_num;
    logic [NW-1:0] num;
    logic [CW-1:0] digit_count;
    logic          entry_done;
    logic [2:0]    done_op;
    logic          overflow;

    always #5 clk = ~clk;

    num_entry #(.NumDigits(N)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .button_valid_i (button_valid),
        .button_i       (button),
        .load_valid_i   (load_valid),
        .load_num_i     (load_num),
        .num_o          (num),
        .digit_count_o  (digit_count),
        .entry_done_o   (entry_done),
        .done_op_o      (done_op),
        .overflow_o     (overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the number is the list of entered digits plus a count of fraction digits.
    int            mode;
    int            digs[$];
    int            frac;
    logic [NW-1:0] m_num;
    int            m_cnt;
    logic          m_done;
    logic [2:0]    m_op;
    logic          m_ovf;

    function automatic void rebuild();
        longint sig = 0;
        foreach (digs[i]) sig = sig * 16 + digs[i];
        m_num = {1'b0, 1'b0, EW'(frac), sig[4*N-1:0]};
        m_cnt = digs.size();
    endfunction

    function automatic void model_clear();
        mode  = M_IDLE;
        digs.delete();
        frac  = 0;
        m_num = '0;
        m_cnt = 0;
    endfunction

    function automatic void model_step(input logic r, input logic bv, input logic [4:0] b,
                                       input logic lv, input logic [NW-1:0] ln);
        int d;
        m_done = 1'b0;
        m_op   = OP_NONE;
        m_ovf  = 1'b0;
        if (r || (bv && b == B_CLEAR)) begin
            model_clear();
        end else if (lv) begin
            m_num = ln;
            digs.delete();
            frac  = 0;
            m_cnt = 0;
            mode  = ln[NW-2] ? M_ERR : M_IDLE;
        end else if (bv && mode != M_ERR) begin
            if (b <= 5'd9) begin
                d = int'(b);
                if (mode == M_IDLE) begin
                    digs.delete();
                    frac = 0;
                    if (d != 0) digs.push_back(d);
                    mode = M_INT;
                    rebuild();
                end else if (mode == M_INT && digs.size() == 0 && d == 0) begin
                    rebuild();
                end else if (digs.size() == N) begin
                    m_ovf = 1'b1;
                end else begin
                    digs.push_back(d);
                    if (mode == M_FRAC) frac++;
                    rebuild();
                end
            end else if (b == B_DOT) begin
                if (mode == M_IDLE) begin
                    digs.delete();
                    digs.push_back(0);
                    frac = 0;
                    mode = M_FRAC;
                    rebuild();
                end else if (mode == M_INT) begin
                    if (digs.size() == N) m_ovf = 1'b1;
                    else begin
                        if (digs.size() == 0) digs.push_back(0);
                        mode = M_FRAC;
                        rebuild();
                    end
                end
            end else if (b inside {B_ADD, B_SUB, B_MUL, B_DIV, B_OP_EQ}) begin
                m_done = 1'b1;
                mode   = M_IDLE;
                case (b)
                    B_ADD:   m_op = OP_ADD;
                    B_SUB:   m_op = OP_SUB;
                    B_MUL:   m_op = OP_MUL;
                    B_DIV:   m_op = OP_DIV;
                    default: m_op = OP_NONE;
                endcase
            end
        end
    endfunction

    task automatic step(input logic r, input logic bv, input logic [4:0] b,
                        input logic lv, input logic [NW-1:0] ln);
        @(negedge clk);
        rst = r; button_valid = bv; button = b; load_valid = lv; load_num = ln;
        @(posedge clk);
        #1;
        model_step(r, bv, b, lv, ln);
        rst = 1'b0; button_valid = 1'b0; load_valid = 1'b0;
        check_eq("num", 64'(num), 64'(m_num));
        check_eq("digit_count", 64'(digit_count), 64'(m_cnt));
        check_eq("entry_done", 64'(entry_done), 64'(m_done));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        if (m_done) check_eq("done_op", 64'(done_op), 64'(m_op));
    endtask

    task automatic press(input logic [4:0] b);
        step(1'b0, 1'b1, b, 1'b0, '0);
    endtask

    function automatic logic [63:0] sig_of();
        return 64'(num[4*N-1:0]);
    endfunction

    function automatic logic [63:0] exp_of();
        return 64'(num[4*N+EW-1:4*N]);
    endfunction

    function automatic logic [NW-1:0] rand_num(input logic err);
        logic [NW-1:0] v;
        v = NW'({$urandom, $urandom});
        v[NW-2] = err;
        return v;
    endfunction

    initial begin
        int ovf_seen;
        logic [NW-1:0] ln;
        rst = 1'b1; button_valid = 1'b0; button = '0; load_valid = 1'b0; load_num = '0;
        model_clear();

        // Reset state
        step(1'b1, 1'b0, '0, 1'b0, '0);
        check_eq("reset_num", 64'(num), 64'd0);
        check_eq("reset_op", 64'(done_op), 64'(OP_NONE));

        // 1 2 . 5 ADD
        press(B_1); press(B_2); press(B_DOT); press(B_5);
        check_eq("r35_sig", sig_of(), 64'h125);
        check_eq("r35_exp", exp_of(), 64'd1);
        check_eq("r35_cnt", 64'(digit_count), 64'd3);
        press(B_ADD);
        check_eq("r35_done", 64'(entry_done), 64'd1);
        check_eq("r35_op", 64'(done_op), 64'(OP_ADD));
        check_eq("r35_hold", sig_of(), 64'h125);

        // Trailing dot: 1 2 . EQ
        press(B_CLEAR); press(B_1); press(B_2); press(B_DOT); press(B_OP_EQ);
        check_eq("r29_sig", sig_of(), 64'h12);
        check_eq("r29_exp", exp_of(), 64'd0);
        check_eq("r29_op", 64'(done_op), 64'(OP_NONE));

        // Leading zeros and overflow
        press(B_CLEAR); press(B_0); press(B_0); press(B_7);
        check_eq("r36_sig7", sig_of(), 64'h7);
        check_eq("r36_cnt1", 64'(digit_count), 64'd1);
        ovf_seen = 0;
        for (int i = 0; i < 9; i++) begin
            press(B_9);
            ovf_seen += int'(overflow);
        end
        check_eq("r36_ovf", 64'(ovf_seen), 64'd2);
        check_eq("r36_sig", sig_of(), 64'h79999999);
        press(B_DOT);
        check_eq("r25_dot_ovf", 64'(overflow), 64'd1);

        // Dot first, then second dot ignored
        press(B_CLEAR); press(B_DOT); press(B_0); press(B_5);
        check_eq("r37_sig", sig_of(), 64'h5);
        check_eq("r37_exp", exp_of(), 64'd2);
        check_eq("r37_cnt", 64'(digit_count), 64'd3);
        press(B_DOT);
        check_eq("r37_no_ovf", 64'(overflow), 64'd0);

        // Error load
        ln = rand_num(1'b1);
        step(1'b0, 1'b0, '0, 1'b1, ln);
        press(B_3); press(B_ADD);
        check_eq("r38_no_done", 64'(entry_done), 64'd0);
        check_eq("r38_err", 64'(num[NW-2]), 64'd1);
        press(B_CLEAR);
        check_eq("r38_clear", 64'(num), 64'd0);

        // Load beats digit; clear beats load
        ln = rand_num(1'b0);
        step(1'b0, 1'b1, B_4, 1'b1, ln);
        check_eq("r39_load", 64'(num), 64'(ln));
        press(B_4);
        check_eq("r39_restart", 64'(num), 64'h4);
        step(1'b0, 1'b1, B_CLEAR, 1'b1, rand_num(1'b0));
        check_eq("clr_over_load", 64'(num), 64'd0);

        // Reset mid-entry
        press(B_3); press(B_DOT); press(B_1);
        step(1'b1, 1'b1, B_5, 1'b0, '0);
        check_eq("r40_num", 64'(num), 64'd0);
        check_eq("r40_cnt", 64'(digit_count), 64'd0);
        press(B_8);
        check_eq("r40_sig", sig_of(), 64'h8);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r, r2;
            logic [4:0] b;
            r  = int'($urandom_range(0, 99));
            r2 = int'($urandom_range(0, 99));
            if (r2 < 55)      b = 5'($urandom_range(0, 9));
            else if (r2 < 65) b = B_DOT;
            else if (r2 < 78) b = 5'($urandom_range(11, 15));
            else if (r2 < 80) b = B_CLEAR;
            else              b = 5'($urandom_range(17, 31));
            if (r < 1)        step(1'b1, 1'b1, b, 1'b0, '0);
            else if (r < 4)   step(1'b0, $urandom_range(0, 1) == 1, b, 1'b1,
                                   rand_num($urandom_range(0, 3) == 0));
            else if (r < 90)  step(1'b0, 1'b1, b, 1'b0, '0);
            else              step(1'b0, 1'b0, 5'($urandom), 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/num_entry.md
NUM_ENTRY -- requirements
Module: num_entry

Interface
REQ-001 Parameter NumDigits, default calc_pkg::NumDigits (8), number of BCD significand digits; legal range 2..16.
REQ-002 Parameter ExpW, default $clog2(NumDigits), exponent width.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 button_valid_i  in  1  one-cycle strobe qualifying button_i.
REQ-006 button_i  in  5  calc_pkg::active_button_t of the pressed key.
REQ-007 load_valid_i  in  1  strobe: replace the displayed number with load_num_i (ALU result or memory recall).
REQ-008 load_num_i  in  2+ExpW+4*NumDigits  {sign, error, exponent, significand} in calc_pkg::num_t field order.
REQ-009 num_o  out  2+ExpW+4*NumDigits  current number, same layout; value = (-1)^sign * significand * 10^-exponent.
REQ-010 digit_count_o  out  $clog2(NumDigits+1)  significant digits entered so far.
REQ-011 entry_done_o  out  1  one-cycle pulse: entry terminated by an operator or equals key.
REQ-012 done_op_o  out  3  calc_pkg::op_t of the terminating key (OP_NONE for equals), valid with entry_done_o.
REQ-013 overflow_o  out  1  one-cycle pulse: digit or dot rejected.

Function
REQ-014 FSM states: S_IDLE (showing loaded/reset value), S_INT (integer digits), S_FRAC (after dot), S_ERROR.
REQ-015 All outputs are registered; effects of an input strobe appear on outputs exactly one cycle later.
REQ-016 Same-cycle priority: rst_i > B_CLEAR > load_valid_i > other buttons; a lower-priority strobe in the same cycle is dropped.
REQ-017 B_CLEAR from any state: num_o = all zero, digit_count_o = 0, S_IDLE.
REQ-018 load_valid_i: num_o = load_num_i, digit_count_o = 0; next state S_ERROR if load_num_i.error, else S_IDLE.
REQ-019 Digit in S_IDLE: num_o restarts as {sign 0, error 0, exponent 0, significand = digit}; to S_INT; digit_count_o = 1, except digit 0 gives digit_count_o = 0.
REQ-020 Digit in S_INT with digit_count_o = 0 and digit 0: no change (leading-zero suppression).
REQ-021 Digit in S_INT/S_FRAC with digit_count_o < NumDigits: significand shifted left one digit with new BCD in the low digit; digit_count_o incremented; in S_FRAC exponent also incremented.
REQ-022 Digit with digit_count_o = NumDigits: num_o unchanged, overflow_o pulses.
REQ-023 B_DOT in S_IDLE: num_o = 0, digit_count_o = 1 (implicit leading zero), to S_FRAC.
REQ-024 B_DOT in S_INT: to S_FRAC; digit_count_o = max(digit_count_o, 1); significand unchanged.
REQ-025 B_DOT in S_INT with digit_count_o = NumDigits: rejected, overflow_o pulses, state unchanged.
REQ-026 B_DOT in S_FRAC: ignored, no overflow pulse.
REQ-027 Invariant: exponent <= NumDigits-1 in all reachable states.
REQ-028 Op key (DIV/MUL/SUB/ADD) or B_OP_EQ in S_INT/S_FRAC/S_IDLE: entry_done_o pulses; done_op_o = button2op(button_i); num_o holds; to S_IDLE.
REQ-029 Trailing dot with no fraction digits ("12." then op): num_o = 12, exponent 0.
REQ-030 In S_ERROR every button except B_CLEAR is ignored; num_o.error stays 1; no pulses.
REQ-031 Memory, percent, sqrt, B_NONE and B_UNKNOWN buttons: no effect in any state.
REQ-032 button_valid_i low: button_i is don't-care.

Reset
REQ-033 rst_i high at a clock edge: state S_IDLE; num_o all zero; digit_count_o 0; entry_done_o, overflow_o 0; done_op_o OP_NONE.
REQ-034 Reset mid-entry discards partial entry; the first strobe after release is processed normally.

Verification
REQ-035 Keys 1,2,DOT,5 then ADD -> num_o significand 0x125, exponent 1, digit_count_o 3; entry_done_o pulse with done_op_o OP_ADD.
REQ-036 Keys 0,0,7 -> significand 7, digit_count_o 1; nine more 9s at NumDigits=8 -> seven accepted, two overflow_o pulses, significand 0x79999999.
REQ-037 DOT then 0,5 -> significand 0x005, exponent 2, digit_count_o 3; a second DOT is ignored without overflow.
REQ-038 load_num_i with error=1 -> S_ERROR; digits and ops ignored with no pulses; CLEAR -> num_o 0, S_IDLE.
REQ-039 Same cycle load_valid_i and digit 4 -> num_o = load_num_i; next digit 4 restarts entry with significand 4.
REQ-040 rst_i asserted after keys 3,DOT,1 -> next cycle all outputs at reset values; key 8 -> significand 8.
